// File: rtl/mini_alu_seq_mul_pkg.sv
// Shared definitions for the MiniAlu sequential multiplier.
// Holds the FSM state encoding, the default operand width and the latency
// macro the ALU control uses to size its instruction-pointer stall counter.

`ifndef MINI_ALU_SEQ_MUL_MACROS
`define MINI_ALU_SEQ_MUL_MACROS
// Cycles from the accepting edge to the oDone cycle for a given width.
`define MUL_LATENCY(w) ((w) + 1)
`endif

package mini_alu_seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/mini_alu_seq_mul_if.sv
// Handshake/data bundle between the ALU control (master) and the multiplier (slave).
//   i_start    request, sampled only in IDLE or DONE
//   i_signed   1 = two's-complement operands, sampled with i_start
//   i_a, i_b   operands, sampled with i_start
//   o_busy     high while iterating
//   o_done     single-cycle pulse, o_result/o_overflow valid
//   o_result   2*WIDTH-bit product, held until the next accepted start
//   o_overflow product does not fit in WIDTH bits for the selected signedness

interface mini_alu_seq_mul_if #(
    parameter int WIDTH = 16
);
    logic                 i_start;
    logic                 i_signed;
    logic [WIDTH-1:0]     i_a;
    logic [WIDTH-1:0]     i_b;
    logic                 o_busy;
    logic                 o_done;
    logic [2*WIDTH-1:0]   o_result;
    logic                 o_overflow;

    modport master (
        output i_start, i_signed, i_a, i_b,
        input  o_busy, o_done, o_result, o_overflow
    );

    modport slave (
        input  i_start, i_signed, i_a, i_b,
        output o_busy, o_done, o_result, o_overflow
    );
endinterface

// File: rtl/mini_alu_twos_abs.sv
// Combinational magnitude / conditional negate.
//   i_val        value to process
//   i_signed     treat i_val as two's complement: negate when its MSB is set
//   i_force_neg  negate unconditionally (used for final sign correction)
//   o_val        result; |most-negative| stays representable as an unsigned value
//   o_neg        1 when negation was applied

module mini_alu_twos_abs #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_signed,
    input  logic             i_force_neg,
    output logic [WIDTH-1:0] o_val,
    output logic             o_neg
);

    assign o_neg = (i_signed & i_val[WIDTH-1]) | i_force_neg;
    assign o_val = o_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mini_alu_seq_mul.sv
// Multi-cycle shift-add multiplier for the MiniAlu MUL opcode.
// Fixed latency: start sampled at edge t0, busy for WIDTH cycles, done pulse
// in cycle t0+WIDTH+1. Signed operands are reduced to magnitudes on entry and
// the product sign is restored on the last iteration.
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset
//   bus    handshake/data bundle (slave side)
//
// state   | meaning
// IDLE    | waiting for i_start, result registers hold last product
// RUN     | one shift-add iteration per cycle, o_busy high
// DONE    | one-cycle o_done pulse; i_start here starts the next multiply

module mini_alu_seq_mul
    import mini_alu_seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mini_alu_seq_mul_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t           r_state;
    mul_state_t           w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [2*WIDTH:0]     r_acc;
    logic                 r_neg;
    logic                 r_signed;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH:0]       w_upper_sum;
    logic [2*WIDTH:0]     w_acc_next;
    logic [2*WIDTH-1:0]   w_result;
    logic                 w_res_neg_unused;
    logic [WIDTH-1:0]     w_hi_u;
    logic [WIDTH:0]       w_hi_s;
    logic                 w_ovf;

    mini_alu_twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_val       (bus.i_a),
        .i_signed    (bus.i_signed),
        .i_force_neg (1'b0),
        .o_val       (w_mag_a),
        .o_neg       (w_neg_a)
    );

    mini_alu_twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_val       (bus.i_b),
        .i_signed    (bus.i_signed),
        .i_force_neg (1'b0),
        .o_val       (w_mag_b),
        .o_neg       (w_neg_b)
    );

    // Sign correction works on the accumulator value being written this edge,
    // so the result is ready in the same cycle the FSM enters DONE.
    mini_alu_twos_abs #(.WIDTH(2*WIDTH)) u_fix_sign (
        .i_val       (w_acc_next[2*WIDTH-1:0]),
        .i_signed    (1'b0),
        .i_force_neg (r_neg),
        .o_val       (w_result),
        .o_neg       (w_res_neg_unused)
    );

    assign w_accept = bus.i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Upper WIDTH+1 bits absorb the carry, so magnitudes up to 2^WIDTH never wrap.
    assign w_upper_sum = r_acc[2*WIDTH:WIDTH] + (r_mag_b[0] ? {1'b0, r_mag_a} : '0);
    assign w_acc_next  = {1'b0, w_upper_sum, r_acc[WIDTH-1:1]};

    assign w_hi_u = w_result[2*WIDTH-1:WIDTH];
    assign w_hi_s = w_result[2*WIDTH-1:WIDTH-1];
    assign w_ovf  = r_signed ? !((w_hi_s == '0) || (w_hi_s == '1)) : (w_hi_u != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.i_start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)      w_next_state = ST_DONE;
            ST_DONE: w_next_state = bus.i_start ? ST_RUN : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy = (r_state == ST_RUN);
        bus.o_done = (r_state == ST_DONE);
    end

    assign bus.o_result   = r_result;
    assign bus.o_overflow = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_signed <= bus.i_signed;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_acc_next;
            r_mag_b <= r_mag_b >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_result;
                r_ovf    <= w_ovf;
            end
        end
    end

endmodule
